// File: rtl/perm_det_pkg.sv
// Shared definitions for the permutation window detector.
//   - colour codes of the ball sorter (green, blue, red)
//   - default parameter values
//   - controller state enumeration
package perm_det_pkg;

  localparam int unsigned GC = 0;
  localparam int unsigned BC = 1;
  localparam int unsigned RC = 2;

  localparam int unsigned SYM_W_DEF   = 2;
  localparam int unsigned NUM_SYM_DEF = 3;
  localparam int unsigned OVERLAP_DEF = 1;
  localparam int unsigned CNT_W_DEF   = 8;

  // EMPTY: nothing held, FILL: partial window, ARMED: NUM_SYM-1 symbols held
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } det_state_e;

endpackage

// File: rtl/perm_window_detector_if.sv
// Symbol stream and result bundle of the permutation window detector.
//   master: drives clr, in_valid, in_sym; observes det, det_q, match_cnt, err
//   slave : the detector
interface perm_window_detector_if
  import perm_det_pkg::*;
#(
  parameter int unsigned SYM_W = SYM_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             clr;
  logic             in_valid;
  logic [SYM_W-1:0] in_sym;
  logic             det;
  logic             det_q;
  logic [CNT_W-1:0] match_cnt;
  logic             err;

  modport master (
    output clr, in_valid, in_sym,
    input  det, det_q, match_cnt, err
  );

  modport slave (
    input  clr, in_valid, in_sym,
    output det, det_q, match_cnt, err
  );

endinterface

// File: rtl/perm_distinct_chk.sv
// Combinational check that NUM_SYM symbols are all pairwise distinct.
//   syms     : NUM_SYM packed symbols of SYM_W bits
//   distinct : 1 when no two symbols are equal
module perm_distinct_chk #(
  parameter int unsigned SYM_W   = 2,
  parameter int unsigned NUM_SYM = 3
) (
  input  logic [NUM_SYM-1:0][SYM_W-1:0] syms,
  output logic                          distinct
);

  always_comb begin
    distinct = 1'b1;
    for (int i = 0; i < int'(NUM_SYM); i++) begin
      for (int j = i + 1; j < int'(NUM_SYM); j++) begin
        if (syms[i] == syms[j]) distinct = 1'b0;
      end
    end
  end

endmodule

// File: rtl/perm_window_detector.sv
// Mealy detector: flags when the last NUM_SYM accepted symbols are a
// permutation of all NUM_SYM codes.
//   clk, rst (sync, active-low)
//   bus.clr       : clear window, counter and error flag
//   bus.in_valid  : in_sym accepted this cycle
//   bus.in_sym    : symbol code, codes >= NUM_SYM are invalid
//   bus.det       : combinational match
//   bus.det_q     : det delayed one cycle
//   bus.match_cnt : saturating match count
//   bus.err       : sticky invalid-code flag
module perm_window_detector
  import perm_det_pkg::*;
#(
  parameter int unsigned SYM_W   = SYM_W_DEF,
  parameter int unsigned NUM_SYM = NUM_SYM_DEF,
  parameter int unsigned OVERLAP = OVERLAP_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  perm_window_detector_if.slave  bus
);

  localparam int unsigned HIST_N  = NUM_SYM - 1;
  localparam int unsigned DEPTH_W = $clog2(NUM_SYM);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  det_state_e                    state, state_nxt;
  logic [DEPTH_W-1:0]            depth, depth_nxt;
  logic [HIST_N-1:0][SYM_W-1:0]  hist, hist_nxt;
  logic [CNT_W-1:0]              cnt, cnt_nxt;
  logic                          err_r, err_nxt;
  logic                          det_q_r;
  logic                          sym_ok;
  logic                          distinct;
  logic                          det_c;
  logic [NUM_SYM-1:0][SYM_W-1:0] window;

  // Extra bit keeps the compare legal when NUM_SYM == 2**SYM_W
  assign sym_ok = {1'b0, bus.in_sym} < (SYM_W+1)'(NUM_SYM);

  // Newest symbol at index 0, followed by the history
  assign window = {hist, bus.in_sym};

  perm_distinct_chk #(
    .SYM_W   (SYM_W),
    .NUM_SYM (NUM_SYM)
  ) u_distinct (
    .syms     (window),
    .distinct (distinct)
  );

  assign det_c = rst && !bus.clr && bus.in_valid && sym_ok &&
                 (state == ARMED) && distinct;

  // Next-state and datapath update; priority clr > invalid > shift
  always_comb begin
    state_nxt = state;
    depth_nxt = depth;
    hist_nxt  = hist;
    cnt_nxt   = cnt;
    err_nxt   = err_r;
    if (bus.clr) begin
      state_nxt = EMPTY;
      depth_nxt = '0;
      cnt_nxt   = '0;
      err_nxt   = 1'b0;
    end else if (bus.in_valid) begin
      if (!sym_ok) begin
        state_nxt = EMPTY;
        depth_nxt = '0;
        err_nxt   = 1'b1;
      end else begin
        for (int i = int'(HIST_N) - 1; i > 0; i--) hist_nxt[i] = hist[i-1];
        hist_nxt[0] = bus.in_sym;
        if (det_c && (OVERLAP == 0)) begin
          state_nxt = EMPTY;
          depth_nxt = '0;
        end else if (state != ARMED) begin
          depth_nxt = depth + DEPTH_W'(1);
          state_nxt = (depth_nxt == DEPTH_W'(HIST_N)) ? ARMED : FILL;
        end
      end
      if (det_c && (cnt != CNT_MAX)) cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Controller state register
  always_ff @(posedge clk) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  // Window, counter and flag registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      depth   <= '0;
      hist    <= '0;
      cnt     <= '0;
      err_r   <= 1'b0;
      det_q_r <= 1'b0;
    end else begin
      depth   <= depth_nxt;
      hist    <= hist_nxt;
      cnt     <= cnt_nxt;
      err_r   <= err_nxt;
      det_q_r <= det_c;
    end
  end

  assign bus.det       = det_c;
  assign bus.det_q     = det_q_r;
  assign bus.match_cnt = cnt;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_perm_window_detector.sv
// Bench for perm_window_detector: four configurations checked against a
// window/alphabet-coverage reference model, a table of directed scenarios
// and a randomized stream.
module tb_perm_window_detector;
  import perm_det_pkg::*;

  logic clk;
  logic rst;

  perm_window_detector_if #(.SYM_W(2), .CNT_W(8)) if0 ();
  perm_window_detector_if #(.SYM_W(2), .CNT_W(8)) if1 ();
  perm_window_detector_if #(.SYM_W(2), .CNT_W(2)) if2 ();
  perm_window_detector_if #(.SYM_W(3), .CNT_W(8)) if3 ();

  perm_window_detector #(.SYM_W(2), .NUM_SYM(3), .OVERLAP(1), .CNT_W(8))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  perm_window_detector #(.SYM_W(2), .NUM_SYM(3), .OVERLAP(0), .CNT_W(8))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  perm_window_detector #(.SYM_W(2), .NUM_SYM(3), .OVERLAP(1), .CNT_W(2))
    u2 (.clk(clk), .rst(rst), .bus(if2));
  perm_window_detector #(.SYM_W(3), .NUM_SYM(5), .OVERLAP(1), .CNT_W(8))
    u3 (.clk(clk), .rst(rst), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Configuration of each instance
  int n_sym [4] = '{3, 3, 3, 5};
  bit ovl   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int cmax  [4] = '{255, 255, 3, 255};
  int smax  [4] = '{3, 3, 3, 7};

  // Per-instance stimulus
  bit clr_i [4];
  bit v_i   [4];
  int sym_i [4];

  // Sampled outputs
  int o_det [4];
  int o_detq[4];
  int o_cnt [4];
  int o_err [4];

  // Reference model: the accepted symbols since the last flush
  int m_len [4];
  int m_hist[4][8];
  int m_cnt [4];
  int m_err [4];
  int m_detq[4];
  bit d_save[4];

  int n_checks;
  int n_err;

  typedef struct {
    bit rst_n;
    bit clr;
    bit v;
    int sym;
    int k;
    bit exp_det;
  } vec_t;

  vec_t tbl[$];

  function automatic void check(string name, int k, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, k, act, exp, $time);
    end
  endfunction

  // Match when the full window plus the new symbol covers every code once
  function automatic bit model_det(int k);
    int mask;
    if (!rst || clr_i[k] || !v_i[k]) return 1'b0;
    if (sym_i[k] >= n_sym[k] || m_len[k] != n_sym[k] - 1) return 1'b0;
    mask = 1 << sym_i[k];
    for (int i = 0; i < n_sym[k] - 1; i++) mask |= 1 << m_hist[k][i];
    return mask == ((1 << n_sym[k]) - 1);
  endfunction

  function automatic void model_edge(int k, bit d);
    if (!rst) begin
      m_len[k] = 0; m_cnt[k] = 0; m_err[k] = 0; m_detq[k] = 0;
      return;
    end
    m_detq[k] = int'(d);
    if (clr_i[k]) begin
      m_len[k] = 0; m_cnt[k] = 0; m_err[k] = 0;
      return;
    end
    if (d && m_cnt[k] < cmax[k]) m_cnt[k]++;
    if (!v_i[k]) return;
    if (sym_i[k] >= n_sym[k]) begin
      m_len[k] = 0; m_err[k] = 1;
    end else if (d && !ovl[k]) begin
      m_len[k] = 0;
    end else begin
      for (int i = 7; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
      m_hist[k][0] = sym_i[k];
      if (m_len[k] < n_sym[k] - 1) m_len[k]++;
    end
  endfunction

  task automatic apply();
    if0.clr = clr_i[0]; if0.in_valid = v_i[0]; if0.in_sym = 2'(sym_i[0]);
    if1.clr = clr_i[1]; if1.in_valid = v_i[1]; if1.in_sym = 2'(sym_i[1]);
    if2.clr = clr_i[2]; if2.in_valid = v_i[2]; if2.in_sym = 2'(sym_i[2]);
    if3.clr = clr_i[3]; if3.in_valid = v_i[3]; if3.in_sym = 3'(sym_i[3]);
  endtask

  task automatic sample();
    o_det[0] = int'(if0.det); o_detq[0] = int'(if0.det_q); o_cnt[0] = int'(if0.match_cnt); o_err[0] = int'(if0.err);
    o_det[1] = int'(if1.det); o_detq[1] = int'(if1.det_q); o_cnt[1] = int'(if1.match_cnt); o_err[1] = int'(if1.err);
    o_det[2] = int'(if2.det); o_detq[2] = int'(if2.det_q); o_cnt[2] = int'(if2.match_cnt); o_err[2] = int'(if2.err);
    o_det[3] = int'(if3.det); o_detq[3] = int'(if3.det_q); o_cnt[3] = int'(if3.match_cnt); o_err[3] = int'(if3.err);
  endtask

  task automatic set_idle();
    for (int k = 0; k < 4; k++) begin
      clr_i[k] = 1'b0; v_i[k] = 1'b0; sym_i[k] = 0;
    end
  endtask

  // One clock: drive, check all instances at negedge, advance model at posedge
  task automatic cycle();
    apply();
    @(negedge clk);
    sample();
    for (int k = 0; k < 4; k++) begin
      d_save[k] = model_det(k);
      check("det", k, o_det[k], int'(d_save[k]));
      check("det_q", k, o_detq[k], m_detq[k]);
      check("match_cnt", k, o_cnt[k], m_cnt[k]);
      check("err", k, o_err[k], m_err[k]);
    end
    @(posedge clk);
    for (int k = 0; k < 4; k++) model_edge(k, d_save[k]);
    #1;
  endtask

  function automatic void row(bit rn, bit c, bit v, int s, int k, bit e);
    vec_t r;
    r.rst_n = rn; r.clr = c; r.v = v; r.sym = s; r.k = k; r.exp_det = e;
    tbl.push_back(r);
  endfunction

  function automatic void stream(int k, int s0, bit e0);
    row(1'b1, 1'b0, 1'b1, s0, k, e0);
  endfunction

  initial begin
    n_checks = 0;
    n_err    = 0;
    for (int k = 0; k < 4; k++) begin
      m_len[k] = 0; m_cnt[k] = 0; m_err[k] = 0; m_detq[k] = 0;
      for (int i = 0; i < 8; i++) m_hist[k][i] = 0;
    end

    // Reset state
    rst = 1'b0;
    set_idle();
    apply();
    repeat (2) @(posedge clk);
    #1;
    sample();
    for (int k = 0; k < 4; k++) begin
      check("rst_det_q", k, o_detq[k], 0);
      check("rst_cnt", k, o_cnt[k], 0);
      check("rst_err", k, o_err[k], 0);
    end
    rst = 1'b1;

    // Overlap: G,B,R,G,B
    row(1, 1, 0, 0, 0, 0);
    stream(0, GC, 0); stream(0, BC, 0); stream(0, RC, 1); stream(0, GC, 1); stream(0, BC, 1);
    row(1, 0, 0, 0, 0, 0);
    // Non-overlap: G,B,R,G,B,R
    row(1, 1, 0, 0, 1, 0);
    stream(1, GC, 0); stream(1, BC, 0); stream(1, RC, 1);
    stream(1, GC, 0); stream(1, BC, 0); stream(1, RC, 1);
    // Repeats
    row(1, 1, 0, 0, 0, 0);
    stream(0, 0, 0); stream(0, 1, 0); stream(0, 1, 0); stream(0, 2, 0); stream(0, 0, 1);
    // Gaps
    row(1, 1, 0, 0, 0, 0);
    stream(0, 0, 0);
    row(1, 0, 0, 0, 0, 0); row(1, 0, 0, 0, 0, 0); row(1, 0, 0, 0, 0, 0);
    stream(0, 1, 0); stream(0, 2, 1);
    // Invalid code
    row(1, 1, 0, 0, 0, 0);
    stream(0, 0, 0); stream(0, 1, 0); stream(0, 3, 0);
    stream(0, 2, 0); stream(0, 0, 0); stream(0, 1, 1);
    // Reset mid-window
    row(1, 1, 0, 0, 0, 0);
    stream(0, 0, 0); stream(0, 1, 0);
    row(0, 0, 0, 0, 0, 0);
    stream(0, 2, 0);
    // Clear with the completing symbol
    row(1, 1, 0, 0, 0, 0);
    stream(0, 0, 0); stream(0, 1, 0);
    row(1, 1, 1, 2, 0, 0);
    // Counter saturation, CNT_W=2
    row(1, 1, 0, 0, 2, 0);
    stream(2, 0, 0); stream(2, 1, 0); stream(2, 2, 1); stream(2, 0, 1);
    stream(2, 1, 1); stream(2, 2, 1); stream(2, 0, 1); stream(2, 1, 1);
    // Wide alphabet, 5 symbols
    row(1, 1, 0, 0, 3, 0);
    stream(3, 4, 0); stream(3, 2, 0); stream(3, 0, 0); stream(3, 3, 0); stream(3, 1, 1);

    foreach (tbl[i]) begin
      set_idle();
      rst = tbl[i].rst_n;
      clr_i[tbl[i].k] = tbl[i].clr;
      v_i[tbl[i].k]   = tbl[i].v;
      sym_i[tbl[i].k] = tbl[i].sym;
      cycle();
      check("tbl_det", tbl[i].k, o_det[tbl[i].k], int'(tbl[i].exp_det));
    end
    rst = 1'b1;
    set_idle();
    cycle();
    sample();
    check("sat_cnt", 2, o_cnt[2], 3);

    // Sticky error until clear, and six overlapping matches counted on dut0
    set_idle();
    clr_i[0] = 1'b1;
    cycle();
    set_idle();
    v_i[0] = 1'b1; sym_i[0] = 3;
    cycle();
    set_idle();
    sample();
    check("err_set", 0, o_err[0], 1);
    repeat (2) cycle();
    sample();
    check("err_hold", 0, o_err[0], 1);
    for (int i = 0; i < 8; i++) begin
      set_idle();
      v_i[0] = 1'b1; sym_i[0] = i % 3;
      cycle();
    end
    set_idle();
    sample();
    check("cnt_six", 0, o_cnt[0], 6);
    check("err_keep", 0, o_err[0], 1);
    clr_i[0] = 1'b1;
    cycle();
    set_idle();
    sample();
    check("err_clr", 0, o_err[0], 0);
    check("cnt_clr", 0, o_cnt[0], 0);

    // Randomized stream on all instances
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 199) != 0);
      for (int k = 0; k < 4; k++) begin
        clr_i[k] = ($urandom_range(0, 49) == 0);
        v_i[k]   = ($urandom_range(0, 99) < 75);
        if ($urandom_range(0, 99) < 90) sym_i[k] = int'($urandom_range(0, n_sym[k] - 1));
        else                            sym_i[k] = int'($urandom_range(0, smax[k]));
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
